// File: rtl/poly_coeff_stream_out_if.sv
// RAM C read port and coefficient output stream for poly_coeff_stream_out.
// The master side is the drain stage; the slave side is the RAM plus the downstream consumer.
interface poly_coeff_stream_out_if #(
    parameter int DEPTH   = 8,
    parameter int COEFF_W = 16
);
    logic               ram_re;
    logic [DEPTH-1:0]   ram_addr;
    logic [COEFF_W-1:0] ram_rdata;
    logic [COEFF_W-1:0] dout_data;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;

    modport master (
        output ram_re, ram_addr, dout_data, dout_valid, dout_last,
        input  ram_rdata, dout_ready
    );
    modport slave (
        input  ram_re, ram_addr, dout_data, dout_valid, dout_last,
        output ram_rdata, dout_ready
    );
endinterface

// File: rtl/poly_coeff_stream_out.sv
// Drains RAM C in address order through a 3-entry FIFO onto a valid/ready stream.
// Define POLY_COEFF_STREAM_CSUBQ_EN to normalise each coefficient into [0, Q).
module poly_coeff_stream_out #(
    parameter int DEPTH   = 8,
    parameter int COEFF_W = 16,
    parameter int Q       = 3329
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    poly_coeff_stream_out_if.master bus,
    output logic busy,
    output logic done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    localparam logic [DEPTH-1:0] ADDR_LAST = '1;

    state_t             state;
    logic               rd_vld;
    logic               rd_last;
    logic [COEFF_W-1:0] fifo_data [3];
    logic [2:0]         fifo_lastf;
    logic [1:0]         rd_ptr;
    logic [1:0]         wr_ptr;
    logic [1:0]         fifo_count;
    logic [COEFF_W-1:0] norm;
    logic               pop;
    logic               wr;
    logic [2:0]         occ_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef POLY_COEFF_STREAM_CSUBQ_EN
    localparam logic signed [COEFF_W:0] QS = (COEFF_W+1)'(Q);
    logic signed [COEFF_W:0] xs;
    logic signed [COEFF_W:0] ys;
    assign xs = {bus.ram_rdata[COEFF_W-1], bus.ram_rdata};
    always_comb begin
        ys = xs;
        if (xs[COEFF_W])  ys = xs + QS;
        else if (xs >= QS) ys = xs - QS;
    end
    assign norm = ys[COEFF_W-1:0];
`else
    assign norm = bus.ram_rdata;
`endif

    assign wr             = rd_vld;
    assign pop            = bus.dout_valid & bus.dout_ready;
    assign bus.dout_valid = (fifo_count != 2'd0);
    assign bus.dout_data  = fifo_data[rd_ptr];
    assign bus.dout_last  = fifo_lastf[rd_ptr];

    // Slots claimed next cycle: FIFO after this cycle's write/pop plus the read now in flight.
    assign occ_next = {1'b0, fifo_count} + 3'(rd_vld) + 3'(bus.ram_re) - 3'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus.ram_re   <= 1'b0;
            bus.ram_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_vld       <= 1'b0;
            rd_last      <= 1'b0;
        end else begin
            rd_vld  <= bus.ram_re;
            rd_last <= bus.ram_re && (bus.ram_addr == ADDR_LAST);
            done    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= FETCH;
                    busy         <= 1'b1;
                    bus.ram_re   <= 1'b1;
                    bus.ram_addr <= '0;
                end
                FETCH: begin
                    if (bus.ram_re) bus.ram_addr <= bus.ram_addr + 1'b1;
                    if (bus.ram_re && bus.ram_addr == ADDR_LAST) begin
                        state      <= DRAIN;
                        bus.ram_re <= 1'b0;
                    end else begin
                        bus.ram_re <= (occ_next < 3'd3);
                    end
                end
                DRAIN: if (pop && bus.dout_last) begin
                    state <= FIN;
                    done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
            fifo_lastf <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr && fifo_count == 2'd3 && !pop)
                $error("poly_coeff_stream_out: FIFO overflow (Q=%0d)", Q);
            if (wr) begin
                fifo_data[wr_ptr]  <= norm;
                fifo_lastf[wr_ptr] <= rd_last;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + 2'(wr) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_poly_coeff_stream_out.sv
// Scoreboard bench for poly_coeff_stream_out: directed RAM contents, queue of expected
// coefficients, and a negedge monitor checking stream order, hold rules and timing.
module tb_poly_coeff_stream_out;
    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    poly_coeff_stream_out_if #(.DEPTH(8), .COEFF_W(16)) bus ();

    poly_coeff_stream_out #(.DEPTH(8), .COEFF_W(16), .Q(3329)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [15:0] exp_vals [256];
    always @(posedge clk) if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int tests = 0, fails = 0;
    exp_t q[$];
    int start_cnt = 0;
    int first_rel, done_rel, last_rel, done_cnt, out_cnt, rd_cnt, outs, max_outs;
    logic re1, busy1, busy260;
    logic [7:0] addr1;
    bit rnd_mode = 0;
    logic rdy_val = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single driver of dout_ready.
    initial begin
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: scoreboard pops, hold checks, timing capture.
    initial begin
        logic        pv, pr, pl;
        logic [15:0] pd;
        int          rel;
        exp_t        e;
        pv = 0; pr = 0; pl = 0; pd = 0;
        forever begin
            @(negedge clk);
            rel = cnt - start_cnt;
            if (reset) begin
                pv = 0; outs = 0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(bus.dout_valid), 1);
                    chk("hold_data", 32'(bus.dout_data), 32'(pd));
                    chk("hold_last", 32'(bus.dout_last), 32'(pl));
                end
                if (rel == 1) begin re1 = bus.ram_re; addr1 = bus.ram_addr; busy1 = busy; end
                if (rel == 260) busy260 = busy;
                if (bus.dout_valid && first_rel < 0) first_rel = rel;
                if (bus.ram_re) rd_cnt++;
                outs = outs + 32'(bus.ram_re) - 32'(bus.dout_valid & bus.dout_ready);
                if (outs > max_outs) max_outs = outs;
                if (bus.dout_valid && bus.dout_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("data[%0d]", out_cnt), 32'(bus.dout_data), 32'(e.d));
                        chk($sformatf("last[%0d]", out_cnt), 32'(bus.dout_last), 32'(e.l));
                    end
                    if (bus.dout_last) last_rel = rel;
                    out_cnt++;
                end
                if (done) begin done_cnt++; done_rel = rel; end
                pv = bus.dout_valid; pr = bus.dout_ready; pd = bus.dout_data; pl = bus.dout_last;
            end
        end
    end

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            e.d = exp_vals[i];
            e.l = (i == 255);
            q.push_back(e);
        end
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        start = 1'b1;
        start_cnt = cnt;
        first_rel = -1; done_rel = -1; last_rel = -1;
        done_cnt = 0; out_cnt = 0; rd_cnt = 0; max_outs = 0;
        re1 = 0; busy1 = 0; busy260 = 1'bx; addr1 = 8'hxx;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (done_cnt == 0 && k < maxc) begin @(posedge clk); k++; end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic fill_linear(input int mul, input int add);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'((i * mul + add) % 3329);
            exp_vals[i] = mem[i];
        end
    endtask

    task automatic check_full_run(input string tag);
        chk({tag, "_re_c1"}, 32'(re1), 1);
        chk({tag, "_addr_c1"}, 32'(addr1), 0);
        chk({tag, "_busy_c1"}, 32'(busy1), 1);
        chk({tag, "_first_valid"}, 32'(first_rel), 3);
        chk({tag, "_last_cycle"}, 32'(last_rel), 258);
        chk({tag, "_done_cycle"}, 32'(done_rel), 259);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
        chk({tag, "_out_cnt"}, 32'(out_cnt), 256);
        chk({tag, "_busy_c260"}, 32'(busy260), 0);
        chk({tag, "_q_empty"}, 32'(q.size()), 0);
    endtask

    initial begin
        logic [15:0] sp_in [6];
        logic [15:0] sp_exp [6];
        sp_in = '{16'hFFFF, 16'd0, 16'd3328, 16'd3329, 16'd6657, 16'hF2FF};
`ifdef POLY_COEFF_STREAM_CSUBQ_EN
        sp_exp = '{16'd3328, 16'd0, 16'd3328, 16'd0, 16'd3328, 16'd0};
`else
        sp_exp = '{16'hFFFF, 16'd0, 16'd3328, 16'd3329, 16'd6657, 16'hF2FF};
`endif
        // Reset state
        @(negedge clk);
        chk("rst_ram_re", 32'(bus.ram_re), 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_data", 32'(bus.dout_data), 0);
        chk("rst_last", 32'(bus.dout_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: linear ramp, ready high
        fill_linear(1, 0);
        rdy_val = 1'b1;
        push_all();
        start_run();
        wait_done(1000);
        check_full_run("s1");

        // 2: normalisation boundary values
        fill_linear(1, 0);
        for (int i = 0; i < 6; i++) begin mem[i] = sp_in[i]; exp_vals[i] = sp_exp[i]; end
        push_all();
        start_run();
        wait_done(1000);
        chk("s2_out_cnt", 32'(out_cnt), 256);

        // 3: random back-pressure
        fill_linear(13, 7);
        push_all();
        rnd_mode = 1;
        start_run();
        wait_done(3000);
        rnd_mode = 0;
        chk("s3_out_cnt", 32'(out_cnt), 256);
        chk("s3_done_cnt", 32'(done_cnt), 1);
        chk("s3_max_outstanding_le3", 32'(max_outs <= 3), 1);

        // 4: ready low for 20 cycles after start
        fill_linear(29, 100);
        push_all();
        rdy_val = 1'b0;
        start_run();
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("s4_reads_stalled", 32'(rd_cnt), 3);
        chk("s4_valid_stalled", 32'(bus.dout_valid), 1);
        chk("s4_data_stalled", 32'(bus.dout_data), 32'(exp_vals[0]));
        rdy_val = 1'b1;
        wait_done(1000);
        chk("s4_out_cnt", 32'(out_cnt), 256);
        chk("s4_max_outstanding", 32'(max_outs), 3);

        // 5: second start mid-transfer is ignored
        fill_linear(1, 0);
        push_all();
        start_run();
        while (cnt - start_cnt < 50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1000);
        repeat (10) @(posedge clk);
        chk("s5_out_cnt", 32'(out_cnt), 256);
        chk("s5_done_cnt", 32'(done_cnt), 1);
        chk("s5_busy_idle", 32'(busy), 0);
        chk("s5_q_empty", 32'(q.size()), 0);

        // 6: reset mid-transfer, then clean rerun
        push_all();
        start_run();
        while (cnt - start_cnt < 100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (300) @(posedge clk);
        chk("s6_abort_no_done", 32'(done_cnt), 0);
        chk("s6_abort_busy", 32'(busy), 0);
        chk("s6_abort_valid", 32'(bus.dout_valid), 0);
        q.delete();
        push_all();
        start_run();
        wait_done(1000);
        check_full_run("s6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/poly_coeff_stream_out.md
# poly_coeff_stream_out

Downstream drain stage for the accumulator RAM (RAM C) of the polyvec basemul-accumulate engine. After the accumulator asserts its `done`, this block reads all `2**DEPTH` Barrett-reduced coefficients from RAM C in address order. It normalises each coefficient to the canonical range [0, Q). It then presents the coefficients on a valid/ready stream with a last marker, for the compression and serialisation stages.

## Interface
- `DEPTH`, default 8: RAM C address width. Coefficient count N = 2**DEPTH.
- `COEFF_W`, default 16: RAM data width, two's complement.
- `Q`, default 3329: Kyber modulus.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse; drives the accumulator `done` rising-edge event.
- `ram_re`  out  1  RAM C read enable.
- `ram_addr`  out  DEPTH  RAM C read address.
- `ram_rdata`  in  COEFF_W  RAM C read data, valid exactly one cycle after `ram_re`.
- `dout_data`  out  COEFF_W  output coefficient, unsigned in [0, Q).
- `dout_valid`  out  1  output valid.
- `dout_ready`  in  1  downstream ready.
- `dout_last`  out  1  high with coefficient N-1.
- `busy`  out  1  high from the first cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last handshake.

## Operation
- Reset values (asynchronous):
  - state = IDLE
  - `ram_re`=0, `ram_addr`=0
  - `dout_valid`=0, `dout_data`=0, `dout_last`=0
  - `busy`=0, `done`=0
  - FIFO empty, in-flight count 0, output count 0
- States: IDLE, FETCH, DRAIN, FIN.
  - IDLE -> FETCH on `start`.
  - FETCH -> DRAIN in the cycle the read of address N-1 is issued.
  - DRAIN -> FIN on the handshake (`dout_valid & dout_ready`) of the coefficient with `dout_last`=1.
  - FIN -> IDLE unconditionally; `done`=1 during FIN.
- `start` is ignored in every state except IDLE.
- Read issue rule (FETCH only): `ram_re`=1 when `fifo_count + inflight < 3`.
  - `ram_re` is registered and never depends combinationally on `dout_ready`.
  - `ram_addr` increments after each issued read and wraps to 0 on entering DRAIN.
- Returning data is normalised, then written into a 3-entry FIFO.
  - Each FIFO entry carries a last flag, set for the address N-1 read.
  - FIFO head drives `dout_data`, `dout_last` and `dout_valid` (= FIFO non-empty).
- Stream rules:
  - Once `dout_valid` rises, data and last stay stable until the handshake.
  - `dout_valid` never drops without a handshake.
- Normalisation, on a signed COEFF_W input x (legal range [-Q, 2Q)):
  - x<0 → x+Q
  - x≥Q → x−Q
  - otherwise x
  - Compute in COEFF_W+1 bits. Inputs outside the legal range are undefined, but must not hang the FSM.
- Simultaneous FIFO write and pop in one cycle are both honoured; the count is unchanged.
- FIFO overflow is impossible by the issue rule. A write to a full FIFO fires an `$error` in simulation.
- Reset asserted mid-transfer: immediate return to IDLE, FIFO flushed, no `done` pulse.

## Timing
- `start` in cycle 0: `busy`=1, `ram_re`=1 with `ram_addr`=0 in cycle 1. `ram_rdata` is valid in cycle 2. `dout_valid`=1 with coefficient 0 in cycle 3.
- With `dout_ready` held high: one coefficient per cycle, no bubbles. Last handshake in cycle N+2, `done` in cycle N+3, `busy` low from cycle N+4.
- Back-pressure: at most 3 reads are outstanding (FIFO entries plus in-flight). Reads resume in the cycle after a pop frees a slot.
- `done` and `dout_last` never coincide: `done` always follows the final handshake by exactly one cycle.

## Configuration
- `POLY_COEFF_STREAM_CSUBQ_EN` defined: normalisation as described above.
- Undefined: `ram_rdata` passes to the FIFO unchanged, the normaliser is removed, and all handshake and timing are identical. Use this when the upstream reduction already guarantees [0, Q).

## Test plan
- RAM preloaded with c[i]=i mod Q, `start`, `dout_ready`=1 → 256 outputs 0..255 in order, first `dout_valid` at cycle 3, `dout_last` only on output 255, `done` at cycle 259.
- RAM holds -1, 0, 3328, 3329, 6657, -3329 (CSUBQ_EN defined) → outputs 3328, 0, 3328, 0, 3328, 0.
- Random `dout_ready` (50% duty) over full transfer → all 256 values correct and in order, data stable while stalled, `ram_re` outstanding never exceeds 3.
- `dout_ready`=0 for 20 cycles after start → exactly 3 reads issued, `dout_valid` held with coefficient 0. On release, the stream completes with correct order.
- Second `start` pulse at cycle 50 of a transfer → ignored, exactly 256 outputs, single `done`.
- `reset` at cycle 100 mid-transfer, then new `start` → no `done` from the aborted run, new run outputs from address 0, identical to the first scenario.
